// File: rtl/pc_pkg.sv
// Shared constants and next-PC select encoding for the program-counter unit.
package pc_pkg;

    localparam int unsigned PC_WORD_SIZE    = 16;
    localparam int unsigned PC_RAS_DEPTH    = 8;
    localparam int unsigned PC_INC_STEP     = 1;
    localparam logic [15:0] PC_RESET_VECTOR = 16'h0000;
    localparam logic [15:0] PC_EXC_VECTOR   = 16'h0008;

    typedef enum logic [2:0] {
        NPC_HOLD = 3'd0,
        NPC_INC  = 3'd1,
        NPC_JMP  = 3'd2,
        NPC_BR   = 3'd3,
        NPC_CALL = 3'd4,
        NPC_RET  = 3'd5,
        NPC_EXC  = 3'd6,
        NPC_ERET = 3'd7
    } npc_sel_e;

endpackage

// File: rtl/pc_unit_if.sv
// Control/status bundle between decode and the PC unit.
// PC_EXC_EN adds exc/eret strobes and the epc readback.
interface pc_unit_if
    import pc_pkg::*;
#(
    parameter int unsigned WORD_SIZE = PC_WORD_SIZE
);

    logic                 stall;
    logic                 load_pc;
    logic                 offset;
    logic                 call;
    logic                 ret;
    logic [WORD_SIZE-1:0] data_in;
    logic [WORD_SIZE-1:0] pc_counter;
    logic                 ras_empty;
    logic                 ras_full;
    logic                 ras_err;
`ifdef PC_EXC_EN
    logic                 exc;
    logic                 eret;
    logic [WORD_SIZE-1:0] epc;

    modport master (
        output stall, load_pc, offset, call, ret, data_in, exc, eret,
        input  pc_counter, ras_empty, ras_full, ras_err, epc
    );
    modport slave (
        input  stall, load_pc, offset, call, ret, data_in, exc, eret,
        output pc_counter, ras_empty, ras_full, ras_err, epc
    );
`else
    modport master (
        output stall, load_pc, offset, call, ret, data_in,
        input  pc_counter, ras_empty, ras_full, ras_err
    );
    modport slave (
        input  stall, load_pc, offset, call, ret, data_in,
        output pc_counter, ras_empty, ras_full, ras_err
    );
`endif

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned DEPTH     = 8
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_push,
    input  logic                 i_pop,
    input  logic [WORD_SIZE-1:0] i_data,
    output logic [WORD_SIZE-1:0] o_top_c,
    output logic                 o_full,
    output logic                 o_empty,
    output logic                 o_ovf_c,
    output logic                 o_unf_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WORD_SIZE-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]     r_sp;
    logic [PTR_W-1:0]     w_sp_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 w_do_push;
    logic                 w_do_pop;

    // Pop has priority; a pop on an empty stack changes nothing.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && !i_pop;
    assign o_top_c   = r_mem[r_sp - PTR_W'(1)];
    assign o_ovf_c   = w_do_push && o_full;
    assign o_unf_c   = i_pop && o_empty;

    always_comb begin : next_ptr
        w_sp_nxt  = r_sp;
        w_cnt_nxt = r_cnt;
        if (w_do_pop) begin
            w_sp_nxt  = r_sp - PTR_W'(1);
            w_cnt_nxt = r_cnt - CNT_W'(1);
        end else if (w_do_push) begin
            w_sp_nxt = r_sp + PTR_W'(1);
            if (!o_full) begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin : state_reg
        if (rst) begin
            r_sp    <= '0;
            r_cnt   <= '0;
            o_full  <= 1'b0;
            o_empty <= 1'b1;
        end else begin
            r_sp    <= w_sp_nxt;
            r_cnt   <= w_cnt_nxt;
            o_full  <= (w_cnt_nxt == CNT_W'(DEPTH));
            o_empty <= (w_cnt_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin : mem_write
        if (w_do_push) begin
            r_mem[r_sp] <= i_data;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Registered program counter with return-address stack.
// Define PC_EXC_EN to add exception entry/return (exc, eret, epc).
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned          WORD_SIZE    = PC_WORD_SIZE,
    parameter int unsigned          RAS_DEPTH    = PC_RAS_DEPTH,
    parameter logic [WORD_SIZE-1:0] RESET_VECTOR = WORD_SIZE'(PC_RESET_VECTOR),
    parameter int unsigned          INC_STEP     = PC_INC_STEP
`ifdef PC_EXC_EN
   ,parameter logic [WORD_SIZE-1:0] EXC_VECTOR   = WORD_SIZE'(PC_EXC_VECTOR)
`endif
)(
    input  logic     clk,
    input  logic     rst,
    pc_unit_if.slave bus
);

    logic [WORD_SIZE-1:0] r_pc;
    logic [WORD_SIZE-1:0] w_pc_nxt;
    logic [WORD_SIZE-1:0] w_pc_inc;
    logic [WORD_SIZE-1:0] w_ras_top;
    npc_sel_e             w_sel;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_ovf;
    logic                 w_unf;
    logic                 w_ras_full;
    logic                 w_ras_empty;
    logic                 r_err;
`ifdef PC_EXC_EN
    logic [WORD_SIZE-1:0] r_epc;
`endif

    assign w_pc_inc = r_pc + WORD_SIZE'(INC_STEP);

    // One action per cycle, highest-priority strobe wins.
    always_comb begin : decode
        w_sel  = NPC_INC;
        w_push = 1'b0;
        w_pop  = 1'b0;
        if (bus.stall) begin
            w_sel = NPC_HOLD;
        end
`ifdef PC_EXC_EN
        else if (bus.exc) begin
            w_sel = NPC_EXC;
        end else if (bus.eret) begin
            w_sel = NPC_ERET;
        end
`endif
        else if (bus.ret) begin
            w_pop = 1'b1;
            w_sel = w_ras_empty ? NPC_INC : NPC_RET;
        end else if (bus.call) begin
            w_push = 1'b1;
            w_sel  = NPC_CALL;
        end else if (bus.load_pc) begin
            w_sel = NPC_JMP;
        end else if (bus.offset) begin
            w_sel = NPC_BR;
        end
    end

    always_comb begin : npc_mux
        w_pc_nxt = w_pc_inc;
        case (w_sel)
            NPC_HOLD: w_pc_nxt = r_pc;
            NPC_JMP:  w_pc_nxt = bus.data_in;
            NPC_CALL: w_pc_nxt = bus.data_in;
            NPC_BR:   w_pc_nxt = r_pc + bus.data_in;
            NPC_RET:  w_pc_nxt = w_ras_top;
`ifdef PC_EXC_EN
            NPC_EXC:  w_pc_nxt = EXC_VECTOR;
            NPC_ERET: w_pc_nxt = r_epc;
`endif
            default:  w_pc_nxt = w_pc_inc;
        endcase
    end

    always_ff @(posedge clk) begin : pc_reg
        if (rst) begin
            r_pc <= RESET_VECTOR;
        end else begin
            r_pc <= w_pc_nxt;
        end
    end

    always_ff @(posedge clk) begin : err_reg
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_ovf || w_unf) begin
            r_err <= 1'b1;
        end
    end

`ifdef PC_EXC_EN
    always_ff @(posedge clk) begin : epc_reg
        if (rst) begin
            r_epc <= RESET_VECTOR;
        end else if (w_sel == NPC_EXC) begin
            r_epc <= r_pc;
        end
    end

    assign bus.epc = r_epc;
`endif

    pc_ras #(
        .WORD_SIZE (WORD_SIZE),
        .DEPTH     (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_pc_inc),
        .o_top_c (w_ras_top),
        .o_full  (w_ras_full),
        .o_empty (w_ras_empty),
        .o_ovf_c (w_ovf),
        .o_unf_c (w_unf)
    );

    assign bus.pc_counter = r_pc;
    assign bus.ras_full   = w_ras_full;
    assign bus.ras_empty  = w_ras_empty;
    assign bus.ras_err    = r_err;

endmodule
